// File: rtl/arm_bitmask_decoder.sv
// Registered A64 DecodeBitMasks: turns immN:immr:imms into wmask/tmask for logical-immediate and bitfield ops.
// Optional macro BMDEC_ILLEGAL_CHECK_EN enables reserved-encoding detection (illegal output, zeroed masks).
module arm_bitmask_decoder #(
  parameter int M = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         immN,
  input  logic [5:0]   immr,
  input  logic [5:0]   imms,
  input  logic         immediate,
  output logic         out_valid,
  output logic [M-1:0] wmask,
  output logic [M-1:0] tmask,
  output logic         illegal
);

  // Handshake: valid-only. A request is taken at every rising edge where in_valid=1;
  // there is no ready, so the producer never stalls. out_valid is in_valid delayed by one edge.

  logic [6:0]   field7;
  logic         any_set;
  logic [2:0]   len_raw;
  logic [2:0]   len;
  logic [5:0]   levels;
  logic [5:0]   s_val;
  logic [5:0]   r_val;
  logic [5:0]   diff;
  logic [5:0]   d_val;
  logic [63:0]  wrep;
  logic [63:0]  trep;
  logic [63:0]  wrot;
  logic         illegal_c;
  logic [M-1:0] wmask_c;
  logic [M-1:0] tmask_c;

  logic         out_valid_q;
  logic [M-1:0] wmask_q;
  logic [M-1:0] tmask_q;
  logic         illegal_q;

  // Element length from the highest set bit of {immN, ~imms}.
  always_comb begin
    field7  = {immN, ~imms};
    any_set = |field7;
    len_raw = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (field7[i]) len_raw = 3'(i);
    end
`ifdef BMDEC_ILLEGAL_CHECK_EN
    len = len_raw;
`else
    len = (len_raw == 3'd0) ? 3'd1 : len_raw;
`endif
  end

  always_comb begin
    levels = 6'((7'd1 << len) - 7'd1);
    s_val  = imms & levels;
    r_val  = immr & levels;
    diff   = s_val - r_val;
    d_val  = diff & levels;
  end

  // Build the element already replicated to 64 bits: bit i belongs to element position
  // i & levels. Rotating the periodic 64-bit word by R equals rotating each element by R.
  always_comb begin
    wrep = '0;
    trep = '0;
    wrot = '0;
    for (int i = 0; i < 64; i++) begin
      wrep[i] = ((6'(i) & levels) <= s_val);
      trep[i] = ((6'(i) & levels) <= d_val);
    end
    for (int i = 0; i < 64; i++) begin
      wrot[i] = wrep[6'(6'(i) + r_val)];
    end
  end

`ifdef BMDEC_ILLEGAL_CHECK_EN
  always_comb begin
    illegal_c = 1'b0;
    if (!any_set)                            illegal_c = 1'b1;
    if ((M == 32) && immN)                   illegal_c = 1'b1;
    if (immediate && (s_val == levels))      illegal_c = 1'b1;
  end
`else
  logic unused_inputs;
  assign unused_inputs = immediate ^ any_set;
  assign illegal_c     = 1'b0;
`endif

  always_comb begin
    wmask_c = wrot[M-1:0];
    tmask_c = trep[M-1:0];
    if (illegal_c) begin
      wmask_c = '0;
      tmask_c = '0;
    end
  end

  // Results only load on a request; idle cycles keep the last decode visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wmask_q     <= '0;
      tmask_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        wmask_q   <= wmask_c;
        tmask_q   <= tmask_c;
        illegal_q <= illegal_c;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign wmask     = wmask_q;
  assign tmask     = tmask_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_arm_bitmask_decoder.sv
// Directed table-driven bench for arm_bitmask_decoder (M=64); reserved-encoding expectations
// follow whether BMDEC_ILLEGAL_CHECK_EN is defined for the build.
module tb_arm_bitmask_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        immN;
  logic [5:0]  immr;
  logic [5:0]  imms;
  logic        immediate;
  logic        out_valid;
  logic [63:0] wmask;
  logic [63:0] tmask;
  logic        illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        n;
    logic [5:0]  r;
    logic [5:0]  s;
    logic        imm;
    logic [63:0] ew;
    logic [63:0] et;
    logic        ei;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  arm_bitmask_decoder #(.M(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .immN      (immN),
    .immr      (immr),
    .imms      (imms),
    .immediate (immediate),
    .out_valid (out_valid),
    .wmask     (wmask),
    .tmask     (tmask),
    .illegal   (illegal)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Driver: apply one vector at the falling edge
  task automatic drive_vec(input vec_t v);
    @(negedge clk);
    in_valid  = 1'b1;
    immN      = v.n;
    immr      = v.r;
    imms      = v.s;
    immediate = v.imm;
  endtask

  task automatic check_vec(input int k, input vec_t v);
    check1 ($sformatf("vec%0d out_valid", k), out_valid, 1'b1);
    check64($sformatf("vec%0d wmask", k), wmask, v.ew);
    check64($sformatf("vec%0d tmask", k), tmask, v.et);
    check1 ($sformatf("vec%0d illegal", k), illegal, v.ei);
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'd0,  6'd7,    1'b1, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 1'b0};
    vecs[1] = '{1'b0, 6'd0,  6'h3C,   1'b1, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b0};
    vecs[2] = '{1'b1, 6'd1,  6'd0,    1'b1, 64'h8000_0000_0000_0000, ONES,                    1'b0};
    vecs[3] = '{1'b1, 6'd4,  6'd63,   1'b0, ONES,                    64'h0FFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4] = '{1'b0, 6'd3,  6'h23,   1'b1, 64'hE001_E001_E001_E001, 64'h0001_0001_0001_0001, 1'b0};
    vecs[5] = '{1'b0, 6'd37, 6'h1F,   1'b0, ONES,                    64'h07FF_FFFF_07FF_FFFF, 1'b0};
    vecs[6] = '{1'b0, 6'd2,  6'h35,   1'b1, 64'hCFCF_CFCF_CFCF_CFCF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0};
    vecs[7] = '{1'b0, 6'd1,  6'h3C,   1'b0, 64'hAAAA_AAAA_AAAA_AAAA, ONES,                    1'b0};
`ifdef BMDEC_ILLEGAL_CHECK_EN
    vecs[8]  = '{1'b0, 6'd0, 6'd63,  1'b0, 64'h0, 64'h0, 1'b1};
    vecs[9]  = '{1'b1, 6'd0, 6'd63,  1'b1, 64'h0, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 6'd0, 6'h3D,  1'b1, 64'h0, 64'h0, 1'b1};
`else
    vecs[8]  = '{1'b0, 6'd0, 6'd63,  1'b0, ONES, ONES, 1'b0};
    vecs[9]  = '{1'b1, 6'd0, 6'd63,  1'b1, ONES, ONES, 1'b0};
    vecs[10] = '{1'b0, 6'd0, 6'h3D,  1'b1, ONES, ONES, 1'b0};
`endif

    rst = 1'b1; in_valid = 1'b0; immN = 1'b0; immr = '0; imms = '0; immediate = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1 ("reset out_valid", out_valid, 1'b0);
    check64("reset wmask", wmask, 64'h0);
    check64("reset tmask", tmask, 64'h0);
    check1 ("reset illegal", illegal, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive_vec(vecs[k]);
      @(posedge clk); #1;
      check_vec(k, vecs[k]);
    end

    // Idle cycle: out_valid drops, masks and illegal hold the last decode
    @(negedge clk);
    in_valid = 1'b0;
    immN = 1'b1; immr = 6'($urandom_range(0, 63)); imms = 6'($urandom_range(0, 62));
    immediate = 1'b0;
    @(posedge clk); #1;
    check1 ("hold out_valid", out_valid, 1'b0);
    check64("hold wmask", wmask, vecs[NV-1].ew);
    check64("hold tmask", tmask, vecs[NV-1].et);
    check1 ("hold illegal", illegal, vecs[NV-1].ei);

    // Reset wins over a simultaneous request
    drive_vec(vecs[0]);
    rst = 1'b1;
    @(posedge clk); #1;
    check1 ("rst+req out_valid", out_valid, 1'b0);
    check64("rst+req wmask", wmask, 64'h0);
    check64("rst+req tmask", tmask, 64'h0);
    check1 ("rst+req illegal", illegal, 1'b0);

    // Back-to-back requests right after reset release
    drive_vec(vecs[2]);
    rst = 1'b0;
    @(posedge clk); #1;
    check_vec(102, vecs[2]);
    drive_vec(vecs[6]);
    @(posedge clk); #1;
    check_vec(106, vecs[6]);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check1("b2b tail out_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arm_bitmask_decoder.md
# arm_bitmask_decoder

Registered decoder for the A64 logical-immediate and bitfield "bitmask" encoding (immN:immr:imms), implementing the architectural DecodeBitMasks function. It sits in the logical functional unit, where it turns instruction fields into the wmask and tmask words used by AND/ORR/EOR-immediate and the SBFM/UBFM/BFM bitfield datapath. Results are registered, and reserved encodings are flagged.

## Interface
- M, default 64: datapath width; legal values 32 and 64.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  decode request this cycle.
- immN  in  1  N field, inst[22].
- immr  in  6  rotate field, inst[21:16].
- imms  in  6  size field, inst[15:10].
- immediate  in  1  1 = logical-immediate form (all-ones element reserved); 0 = bitfield form.
- out_valid  out  1  registered copy of in_valid.
- wmask  out  M  replicated, rotated element mask.
- tmask  out  M  replicated, unrotated top mask.
- illegal  out  1  reserved encoding.

## Operation
- len = index of the highest set bit of the 7-bit value {immN, ~imms}, range 0..6.
- Reserved encoding when any of these holds:
  - no bit is set;
  - M=32 and immN=1;
  - immediate=1 and (imms & levels) == levels.
- levels = 6-bit mask with the low len bits set.
- S = imms & levels; R = immr & levels; esize = 1<<len.
- diff = (S − R) modulo 64 (6-bit wrap); d = diff & levels.
- welem = low S+1 bits set within esize; telem = low d+1 bits set within esize.
- wmask = ROR(welem, R) within esize, replicated M/esize times.
- tmask = telem replicated M/esize times (no rotation).
- When illegal=1, wmask and tmask are 0.
- Decode logic is purely combinational from the inputs; no state is carried between requests.

## Timing
- Latency 1 cycle: inputs sampled at the clk edge where in_valid=1; out_valid, wmask, tmask and illegal update at that edge.
- When in_valid=0 at an edge:
  - out_valid goes to 0;
  - wmask, tmask and illegal hold their previous values.
- Back-to-back requests are accepted every cycle; there is no stall or backpressure.
- Reset values: out_valid=0, wmask=0, tmask=0, illegal=0. Reset has priority over in_valid on the same edge. A request in flight during reset is discarded.

## Configuration
- Macro BMDEC_ILLEGAL_CHECK_EN:
  - Defined: reserved encodings are detected as above, raise illegal and zero both masks.
  - Undefined: the illegal output is tied to 0 and masks are computed from the formulas regardless. len=0 is then treated as len=1.

## Test plan
All cases use M=64 with BMDEC_ILLEGAL_CHECK_EN defined; each result is checked one cycle after in_valid.
- immN=1, immr=0, imms=7, immediate=1 → wmask=0x00000000000000FF, tmask=0x00000000000000FF, illegal=0.
- immN=0, immr=0, imms=0x3C, immediate=1 → wmask=0x5555555555555555, tmask=0x5555555555555555.
- immN=1, immr=1, imms=0, immediate=1 → wmask=0x8000000000000000, tmask=0xFFFFFFFFFFFFFFFF (diff wraps to 63).
- immN=1, immr=4, imms=63, immediate=0 → wmask=0xFFFFFFFFFFFFFFFF, tmask=0x0FFFFFFFFFFFFFFF, illegal=0.
- Reserved encodings:
  - immN=0, imms=63, immediate=0 → illegal=1, both masks 0.
  - immN=1, imms=63, immediate=1 → illegal=1.
- Reset and back-to-back:
  - Assert rst with in_valid=1 → next cycle out_valid=0, wmask=0, tmask=0, illegal=0.
  - Then issue two consecutive requests → both results appear on consecutive cycles.
